// File: rtl/sv_input_loader.sv
// ---------------------------------------------------------------------------
// sv_input_loader
//
// Streams a run of int8 elements out of a 32-bit BRAM onto an AXI-Stream
// master port. Each element is sign-extended to DATA_WIDTH bits and tagged
// with a rolling element index (TID) that selects the downstream MAC.
// The first element may sit at any byte lane of its BRAM word.
//
// Optional feature macro: SV_INPUT_LOADER_PREFETCH_EN
//   When defined, the next BRAM word is read while the current one is being
//   streamed, so word boundaries cost no bubbles when TREADY stays high.
//   When undefined, every word costs a READ and a LATCH cycle.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle request to begin a transfer (ignored if busy)
//   base_addr          byte address of the first element (may be unaligned)
//   num_elements       number of int8 elements to stream
//   busy               high while a transfer is in progress
//   done               one-cycle pulse on the final handshake (or one cycle
//                      after a zero-length start)
//   M_AXIS_*           AXI-Stream master (TDATA, TVALID, TREADY, TLAST, TID)
//   BRAM_*             BRAM port A: word-aligned read address, read enable,
//                      read data one cycle after the enable; write side tied off
// ---------------------------------------------------------------------------
module sv_input_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int C_TID_WIDTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  num_elements,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    output logic [C_TID_WIDTH-1:0] M_AXIS_TID,
    output logic [31:0]            BRAM_addr,
    output logic [31:0]            BRAM_din,
    input  logic [31:0]            BRAM_dout,
    output logic                   BRAM_en,
    output logic [3:0]             BRAM_we,
    output logic                   BRAM_rst,
    output logic                   BRAM_clk
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO = ADDR_WIDTH'(1'b0);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [C_TID_WIDTH-1:0] TID_ZERO  = C_TID_WIDTH'(1'b0);
    localparam logic [C_TID_WIDTH-1:0] TID_ONE   = C_TID_WIDTH'(1'b1);

    // Pick byte lane 'lane' (little-endian) of a BRAM word and sign-extend it.
    function automatic logic [DATA_WIDTH-1:0] sext_lane(
        input logic [BRAM_DATA_WIDTH-1:0] word,
        input logic [1:0]                 lane
    );
        logic signed [7:0] byte_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        return DATA_WIDTH'(byte_v);
    endfunction

    state_t                      state_r;
    state_t                      state_next_s;
    logic [ADDR_WIDTH-1:0]       addr_r;
    logic [ADDR_WIDTH-1:0]       count_r;
    logic [BRAM_DATA_WIDTH-1:0]  word_r;
    logic [C_TID_WIDTH-1:0]      tid_r;
    logic                        zero_done_r;

    logic                        send_s;
    logic                        hs_s;
    logic                        last_s;
    logic                        lane3_s;
    logic                        accept_s;
    logic [ADDR_WIDTH-1:0]       word_addr_s;
    logic                        pf_issue_s;
    logic                        word_from_pf_s;

    // Reset is gated into the stream controls so a beat cannot complete
    // (and done cannot fire) in the cycle that rst is being applied.
    assign send_s      = (state_r == SEND) && !rst;
    assign hs_s        = send_s && M_AXIS_TREADY;
    assign last_s      = (count_r == ADDR_ONE);
    assign lane3_s     = (addr_r[1:0] == 2'd3);
    assign accept_s    = (state_r == IDLE) && start;
    assign word_addr_s = {addr_r[ADDR_WIDTH-1:2], 2'b00};

`ifdef SV_INPUT_LOADER_PREFETCH_EN
    logic [BRAM_DATA_WIDTH-1:0]  pf_buf_r;
    logic                        pf_valid_r;
    logic                        pf_pending_r;
    logic                        pf_done_r;
    logic [ADDR_WIDTH-1:0]       in_word_s;
    logic                        pf_avail_s;
    logic [BRAM_DATA_WIDTH-1:0]  pf_data_s;

    // Elements left in the current word from the present lane upward; if
    // more remain than that, the following word is needed.
    assign in_word_s  = ADDR_WIDTH'(3'd4 - {1'b0, addr_r[1:0]});
    assign pf_issue_s = send_s && !pf_done_r && (count_r > in_word_s);
    // Read data arriving this cycle can be used directly, before it lands
    // in the buffer.
    assign pf_avail_s = pf_valid_r || pf_pending_r;
    assign pf_data_s  = pf_pending_r ? BRAM_dout : pf_buf_r;
`else
    assign pf_issue_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and word-load select
    always_comb begin
        state_next_s   = state_r;
        word_from_pf_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (num_elements != ADDR_ZERO)) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                state_next_s = LATCH;
            end
            LATCH: begin
                state_next_s = SEND;
            end
            SEND: begin
                if (hs_s && last_s) begin
                    state_next_s = IDLE;
                end else if (hs_s && lane3_s) begin
`ifdef SV_INPUT_LOADER_PREFETCH_EN
                    if (pf_avail_s) begin
                        state_next_s   = SEND;
                        word_from_pf_s = 1'b1;
                    end else if (pf_issue_s) begin
                        // Read of the next word leaves this cycle, so its
                        // data is ready in the following (LATCH) cycle.
                        state_next_s = LATCH;
                    end else begin
                        state_next_s = READ;
                    end
`else
                    state_next_s = READ;
`endif
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Address, remaining count, TID and zero-length done bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= ADDR_ZERO;
            count_r     <= ADDR_ZERO;
            tid_r       <= TID_ZERO;
            zero_done_r <= 1'b0;
        end else begin
            zero_done_r <= accept_s && (num_elements == ADDR_ZERO);
            if (accept_s) begin
                addr_r  <= base_addr;
                count_r <= num_elements;
                tid_r   <= TID_ZERO;
            end else if (hs_s) begin
                addr_r  <= addr_r + ADDR_ONE;
                count_r <= count_r - ADDR_ONE;
                tid_r   <= tid_r + TID_ONE;
            end else begin
                addr_r  <= addr_r;
                count_r <= count_r;
                tid_r   <= tid_r;
            end
        end
    end

    // Current word register: filled from BRAM in LATCH or from the prefetch buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r <= {BRAM_DATA_WIDTH{1'b0}};
        end else if (state_r == LATCH) begin
            word_r <= BRAM_dout;
`ifdef SV_INPUT_LOADER_PREFETCH_EN
        end else if (word_from_pf_s) begin
            word_r <= pf_data_s;
`endif
        end else begin
            word_r <= word_r;
        end
    end

`ifdef SV_INPUT_LOADER_PREFETCH_EN
    // Prefetch tracking: one read per word, captured the cycle after issue
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_buf_r     <= {BRAM_DATA_WIDTH{1'b0}};
            pf_valid_r   <= 1'b0;
            pf_pending_r <= 1'b0;
            pf_done_r    <= 1'b0;
        end else if ((state_r == LATCH) || word_from_pf_s) begin
            // A new word is being loaded; its own prefetch has not started.
            pf_valid_r   <= 1'b0;
            pf_pending_r <= 1'b0;
            pf_done_r    <= 1'b0;
        end else begin
            if (pf_pending_r) begin
                pf_buf_r   <= BRAM_dout;
                pf_valid_r <= 1'b1;
            end else begin
                pf_buf_r   <= pf_buf_r;
                pf_valid_r <= pf_valid_r;
            end
            pf_pending_r <= pf_issue_s;
            pf_done_r    <= pf_done_r || pf_issue_s;
        end
    end

    assign BRAM_addr = 32'(pf_issue_s ? (word_addr_s + ADDR_WIDTH'(3'd4)) : word_addr_s);
`else
    assign BRAM_addr = 32'(word_addr_s);
`endif

    assign BRAM_en       = ((state_r == READ) && !rst) || pf_issue_s;
    assign BRAM_din      = 32'h0000_0000;
    assign BRAM_we       = 4'b0000;
    assign BRAM_rst      = rst;
    assign BRAM_clk      = clk;

    assign busy          = (state_r != IDLE) && !rst;
    assign done          = zero_done_r || (hs_s && last_s);
    assign M_AXIS_TVALID = send_s;
    assign M_AXIS_TLAST  = send_s && last_s;
    assign M_AXIS_TDATA  = sext_lane(word_r, addr_r[1:0]);
    assign M_AXIS_TID    = tid_r;

endmodule

// File: doc/sv_input_loader.md
SV_INPUT_LOADER -- requirements
Module: sv_input_loader

Interface
REQ-001: Parameter DATA_WIDTH, default 32: M_AXIS_TDATA width.
REQ-002: Parameter BRAM_DATA_WIDTH, default 32: BRAM word width; exactly 32 is supported.
REQ-003: Parameter ADDR_WIDTH, default 32: width of byte addresses and counts.
REQ-004: Parameter C_TID_WIDTH, default 2: M_AXIS_TID width.
REQ-005: Reset is rst (synchronous, active-high) and the clock is clk; the ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a transfer.
- base_addr  in  ADDR_WIDTH  byte address of the first int8 element; may be unaligned.
- num_elements  in  ADDR_WIDTH  number of int8 elements to stream.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the final beat handshakes.
- M_AXIS_TDATA  out  DATA_WIDTH  sign-extended int8 element.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  final element.
- M_AXIS_TID  out  C_TID_WIDTH  element index mod 2^C_TID_WIDTH (MAC select).
- BRAM_addr  out  32  word-aligned byte address {addr[ADDR_WIDTH-1:2],2'b00}.
- BRAM_din  out  32  tied 0.
- BRAM_dout  in  32  read data, valid 1 cycle after BRAM_en.
- BRAM_en  out  1  read enable.
- BRAM_we  out  4  tied 0.
- BRAM_rst  out  1  equals rst.
- BRAM_clk  out  1  equals clk.

Function
REQ-006: The state machine SHALL have the states IDLE, READ, LATCH and SEND.
- IDLE->READ on start; base_addr and num_elements are latched; busy=1.
- IDLE->IDLE when num_elements=0; done pulses on the next cycle.
REQ-007: In READ, BRAM_en=1 with the current word address; the next state is LATCH.
REQ-008: In LATCH, BRAM_dout SHALL be captured into the word register; the next state is SEND.
REQ-009: In SEND, TVALID=1 and TDATA = the sign-extended byte at lane addr[1:0] (lane 0 = bits 7:0, little-endian).
REQ-010: A beat handshakes when TVALID and TREADY are both high; on handshake the address and count advance by 1 and TID increments, wrapping at 2^C_TID_WIDTH.
REQ-011: TVALID, TDATA, TID and TLAST SHALL hold stable while TREADY=0.
REQ-012: On a lane-3 handshake that is not the final beat, the next state is READ.
REQ-013: An unaligned base_addr SHALL start at lane base_addr[1:0]; lower lanes of the first word are skipped.
REQ-014: TLAST=1 only on the beat where the remaining count is 1.
REQ-015: The final handshake SHALL pulse done for 1 cycle, clear busy and return to IDLE in the same cycle.
REQ-016: start while busy SHALL be ignored.
REQ-017: Latency from start sampled to the first TVALID SHALL be 3 cycles: READ, LATCH, SEND.
REQ-018: The TID counter SHALL reset to 0 on every accepted start.
REQ-019: Outside READ (and prefetch reads), BRAM_en=0.

Reset
REQ-020: While rst=1, the block SHALL be in IDLE with busy=0, done=0, TVALID=0, TLAST=0, TID=0, BRAM_en=0 and BRAM_we=0.
REQ-021: rst mid-transfer SHALL abort on the next edge; no further beats are emitted and no done pulse is produced.

Configuration
REQ-022: With macro SV_INPUT_LOADER_PREFETCH_EN defined, the first SEND cycle of each word SHALL issue a BRAM read of the next word (if any elements remain).
- dout is captured into a prefetch buffer on the following cycle.
- A lane-3 handshake loads the buffer and stays in SEND, giving zero bubbles with TREADY held at 1.
REQ-023: With SV_INPUT_LOADER_PREFETCH_EN undefined, no prefetch buffer exists, and each word costs 2 non-beat cycles (READ and LATCH).

Verification
REQ-024: base_addr=0x100, num=8, TREADY=1, BRAM words 0x04030201 and 0x88070605:
- TDATA sequence 1,2,3,4,5,6,7,0xFFFFFF88.
- TID 0,1,2,3,0,1,2,3; TLAST on beat 8.
- done 12 cycles after start without prefetch, 10 cycles with prefetch.
REQ-025: base_addr=0x102, num=3:
- First read at 0x100, emitting lanes 2 and 3.
- Then a read at 0x104 emitting lane 0 with TLAST.
REQ-026: TREADY low for 5 cycles on beat 2:
- TDATA, TID and TVALID held constant.
- Transfer completes with all beats present and none duplicated.
REQ-027: num_elements=0: no TVALID; done pulses one cycle after start; busy is never seen high by the bench.
REQ-028: rst asserted mid-transfer, then start issued again:
- TVALID=0 the next cycle.
- The new transfer restarts with TID=0 and the correct first element.
REQ-029: A second start during busy has no effect on address, count or beat sequence.
